// File: rtl/formula_sum_isqrt_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : formula_sum_isqrt_fsm
//  Purpose  : Sums the integer square roots of N_ARGS 32-bit arguments using a
//             bank of N_ISQRT external isqrt pipelines, in rounds of N_ISQRT
//             lanes. Operands are latched on accept, so the source may change
//             args right afterwards. A lane-mismatch error flag is sticky.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             arg_vld, args        - request strobe and packed arguments
//             busy                 - request in flight (accept to res_vld)
//             res_vld, res         - one-cycle result pulse, held sum
//             err                  - sticky partial-lane-valid error
//             isqrt_x_vld, isqrt_x - operands to the isqrt bank
//             isqrt_y_vld, isqrt_y - roots returned by the isqrt bank
//  Revision : 1.0 - initial release
// ============================================================================
module formula_sum_isqrt_fsm #(
    parameter int N_ARGS  = 3,
    parameter int N_ISQRT = 2,
    parameter int RES_W   = 16 + $clog2(N_ARGS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arg_vld,
    input  logic [N_ARGS*32-1:0]  args,
    output logic                  busy,
    output logic                  res_vld,
    output logic [RES_W-1:0]      res,
    output logic                  err,
    output logic [N_ISQRT-1:0]    isqrt_x_vld,
    output logic [N_ISQRT*32-1:0] isqrt_x,
    input  logic [N_ISQRT-1:0]    isqrt_y_vld,
    input  logic [N_ISQRT*16-1:0] isqrt_y
);

    localparam int C_ROUNDS = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
    localparam int C_RND_W  = $clog2(C_ROUNDS + 1);
    // Operand table is sized to the full index range of the round counter so
    // the round register can index it directly without width adaptation.
    localparam int C_TBL    = 2 ** C_RND_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [N_ARGS*32-1:0]    r_arg_q;
    logic [C_RND_W-1:0]      r_round;
    logic [RES_W-1:0]        r_acc;
    logic [RES_W-1:0]        r_res;
    logic                    r_res_vld;
    logic                    r_err;

    logic [N_ISQRT*32-1:0]   w_round_ops [C_TBL];
    logic [RES_W-1:0]        w_lane_sum;
    logic                    w_accept;
    logic                    w_all_vld;
    logic                    w_partial_vld;
    logic                    w_last_round;

    // Per-round operand vectors; lanes beyond the last argument carry zero.
    for (genvar r = 0; r < C_TBL; r++) begin : g_round
        for (genvar j = 0; j < N_ISQRT; j++) begin : g_lane
            if (r * N_ISQRT + j < N_ARGS) begin : g_arg
                assign w_round_ops[r][j*32 +: 32] = r_arg_q[(r*N_ISQRT + j)*32 +: 32];
            end else begin : g_zero
                assign w_round_ops[r][j*32 +: 32] = 32'd0;
            end
        end
    end

    always_comb begin
        w_lane_sum = '0;
        for (int j = 0; j < N_ISQRT; j++) begin
            w_lane_sum = w_lane_sum + RES_W'(isqrt_y[j*16 +: 16]);
        end
    end

    // A request in the res_vld cycle is refused: busy is still high there.
    assign w_accept      = (r_state == S_IDLE) && arg_vld && !r_res_vld;
    assign w_all_vld     = &isqrt_y_vld;
    assign w_partial_vld = (|isqrt_y_vld) && !w_all_vld;
    assign w_last_round  = (r_round == C_RND_W'(C_ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (w_all_vld) w_state_next = w_last_round ? S_DONE : S_ISSUE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arg_q   <= '0;
            r_round   <= '0;
            r_acc     <= '0;
            r_res     <= '0;
            r_res_vld <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_res_vld <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_arg_q <= args;
                        r_acc   <= '0;
                        r_round <= '0;
                    end
                end
                S_WAIT: begin
                    // Only a complete beat is summed; a partial one just flags
                    // the error and the FSM keeps waiting for a full beat.
                    if (w_all_vld) begin
                        r_acc <= r_acc + w_lane_sum;
                        if (!w_last_round) begin
                            r_round <= r_round + C_RND_W'(1);
                        end
                    end else if (w_partial_vld) begin
                        r_err <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_res     <= r_acc;
                    r_res_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE) || r_res_vld;
    assign res_vld     = r_res_vld;
    assign res         = r_res;
    assign err         = r_err;
    assign isqrt_x_vld = {N_ISQRT{r_state == S_ISSUE}};
    assign isqrt_x     = w_round_ops[r_round];

endmodule
`default_nettype wire

// File: tb/tb_formula_sum_isqrt_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_formula_sum_isqrt_fsm
//  Purpose  : Directed self-checking bench. Instance A uses 3 args / 2 lanes,
//             instance B uses 4 args / 4 lanes. Each has a latency-3 isqrt
//             model; instance A's roots can be overridden by hand.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_formula_sum_isqrt_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mrst;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Instance A: N_ARGS=3, N_ISQRT=2, RES_W=18
    logic        arg_vld_a;
    logic [95:0] args_a;
    logic        busy_a, res_vld_a, err_a;
    logic [17:0] res_a;
    logic [1:0]  xv_a, yv_a;
    logic [63:0] x_a;
    logic [31:0] y_a;

    // Instance B: N_ARGS=4, N_ISQRT=4, RES_W=19
    logic         arg_vld_b;
    logic [127:0] args_b;
    logic         busy_b, res_vld_b, err_b;
    logic [18:0]  res_b;
    logic [3:0]   xv_b, yv_b;
    logic [127:0] x_b;
    logic [63:0]  y_b;

    formula_sum_isqrt_fsm #(.N_ARGS(3), .N_ISQRT(2)) dut_a (
        .clk(clk), .rst(rst), .arg_vld(arg_vld_a), .args(args_a),
        .busy(busy_a), .res_vld(res_vld_a), .res(res_a), .err(err_a),
        .isqrt_x_vld(xv_a), .isqrt_x(x_a), .isqrt_y_vld(yv_a), .isqrt_y(y_a)
    );

    formula_sum_isqrt_fsm #(.N_ARGS(4), .N_ISQRT(4)) dut_b (
        .clk(clk), .rst(rst), .arg_vld(arg_vld_b), .args(args_b),
        .busy(busy_b), .res_vld(res_vld_b), .res(res_b), .err(err_b),
        .isqrt_x_vld(xv_b), .isqrt_x(x_b), .isqrt_y_vld(yv_b), .isqrt_y(y_b)
    );

    function automatic logic [15:0] f_isqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [31:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = {16'd0, r | (16'd1 << b)};
            if (t * t <= x) r = t[15:0];
        end
        return r;
    endfunction

    // Latency-3 isqrt models (not reset by rst, so stale results can appear)
    logic [31:0] yn_a;
    logic [63:0] yn_b;
    logic [1:0]  mva [3];
    logic [31:0] mya [3];
    logic [3:0]  mvb [3];
    logic [63:0] myb [3];
    logic        man_a;
    logic [1:0]  man_yv_a;
    logic [31:0] man_y_a;

    always_comb begin
        yn_a = '0;
        yn_b = '0;
        for (int j = 0; j < 2; j++) yn_a[j*16 +: 16] = f_isqrt(x_a[j*32 +: 32]);
        for (int j = 0; j < 4; j++) yn_b[j*16 +: 16] = f_isqrt(x_b[j*32 +: 32]);
    end

    always @(posedge clk) begin
        if (mrst) begin
            for (int s = 0; s < 3; s++) begin
                mva[s] <= '0; mya[s] <= '0; mvb[s] <= '0; myb[s] <= '0;
            end
        end else begin
            mva[0] <= xv_a; mya[0] <= yn_a;
            mvb[0] <= xv_b; myb[0] <= yn_b;
            for (int s = 1; s < 3; s++) begin
                mva[s] <= mva[s-1]; mya[s] <= mya[s-1];
                mvb[s] <= mvb[s-1]; myb[s] <= myb[s-1];
            end
        end
    end

    assign yv_a = man_a ? man_yv_a : mva[2];
    assign y_a  = man_a ? man_y_a  : mya[2];
    assign yv_b = mvb[2];
    assign y_b  = myb[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Request on A at cycle 0; watch cycles 1..22. Optionally hold a second
    // request with other args high during cycles 2..10.
    task automatic run_a(input logic [95:0] a, input bit junk,
                         output int first, output int pulses,
                         output logic busy1, output logic busy_after,
                         output logic [63:0] x5, output logic [1:0] xv5);
        first = -1; pulses = 0; busy1 = 1'b0; busy_after = 1'b1;
        x5 = '0; xv5 = '0;
        args_a = a; arg_vld_a = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            args_a    = {3{32'd100}};
            arg_vld_a = junk && (c >= 2) && (c <= 10);
            if (c == 1) busy1 = busy_a;
            if (c == 5) begin x5 = x_a; xv5 = xv_a; end
            if (first >= 0 && c == first + 1) busy_after = busy_a;
            if (res_vld_a) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        arg_vld_a = 1'b0;
    endtask

    task automatic run_b(input logic [127:0] a, output int first, output int pulses);
        first = -1; pulses = 0;
        args_b = a; arg_vld_b = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            arg_vld_b = 1'b0;
            args_b    = '1;
            if (res_vld_b) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
    endtask

    initial begin
        int          first, pulses;
        logic        busy1, busy_after, err4, quiet;
        logic [63:0] x5;
        logic [1:0]  xv5;

        rst = 1'b1; mrst = 1'b1;
        arg_vld_a = 1'b0; args_a = '0; arg_vld_b = 1'b0; args_b = '0;
        man_a = 1'b0; man_yv_a = '0; man_y_a = '0;
        repeat (3) tick();
        rst = 1'b0; mrst = 1'b0;
        tick();

        // Reset state
        chk("rst_busy_a",  32'(busy_a),    32'd0);
        chk("rst_vld_a",   32'(res_vld_a), 32'd0);
        chk("rst_res_a",   32'(res_a),     32'd0);
        chk("rst_err_a",   32'(err_a),     32'd0);
        chk("rst_xvld_a",  32'(xv_a),      32'd0);
        chk("rst_busy_b",  32'(busy_b),    32'd0);
        chk("rst_xvld_b",  32'(xv_b),      32'd0);

        // {4,9,16}: two rounds, 2+3+4 = 9 at cycle 10
        run_a({32'd16, 32'd9, 32'd4}, 1'b0, first, pulses, busy1, busy_after, x5, xv5);
        chk("t1_cycle",     32'(first),       32'd10);
        chk("t1_pulses",    32'(pulses),      32'd1);
        chk("t1_res",       32'(res_a),       32'd9);
        chk("t1_busy_c1",   32'(busy1),       32'd1);
        chk("t1_busy_post", 32'(busy_after),  32'd0);
        chk("t1_r2_xvld",   32'(xv5),         32'd3);
        chk("t1_r2_lane0",  x5[31:0],         32'd16);
        chk("t1_r2_lane1",  x5[63:32],        32'd0);

        // All ones: 3 * 65535 = 196605, fits in 18 bits
        run_a({3{32'hFFFF_FFFF}}, 1'b0, first, pulses, busy1, busy_after, x5, xv5);
        chk("t2_cycle",  32'(first),  32'd10);
        chk("t2_res",    32'(res_a),  32'd196605);

        // Second request held during cycles 2..10 is ignored
        run_a({32'd16, 32'd9, 32'd4}, 1'b1, first, pulses, busy1, busy_after, x5, xv5);
        chk("t3_cycle",  32'(first),  32'd10);
        chk("t3_pulses", 32'(pulses), 32'd1);
        chk("t3_res",    32'(res_a),  32'd9);

        // Reset during WAIT; stale roots arrive at cycle 4 and must be ignored
        args_a = {32'd16, 32'd9, 32'd4}; arg_vld_a = 1'b1;
        tick(); arg_vld_a = 1'b0;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        chk("t4_busy_rst", 32'(busy_a),    32'd0);
        chk("t4_res_rst",  32'(res_a),     32'd0);
        chk("t4_vld_rst",  32'(res_vld_a), 32'd0);
        quiet = 1'b1;
        for (int c = 4; c <= 12; c++) begin
            tick();
            if (res_vld_a || busy_a || (xv_a != 2'b00)) quiet = 1'b0;
        end
        chk("t4_quiet", 32'(quiet), 32'd1);
        run_a({3{32'd1}}, 1'b0, first, pulses, busy1, busy_after, x5, xv5);
        chk("t4_cycle", 32'(first), 32'd10);
        chk("t4_res",   32'(res_a), 32'd3);
        chk("t4_err",   32'(err_a), 32'd0);

        // B: {0,1,2,100} in one round -> 0+1+1+10 = 12 at cycle 6
        run_b({32'd100, 32'd2, 32'd1, 32'd0}, first, pulses);
        chk("t5_cycle",  32'(first),  32'd6);
        chk("t5_pulses", 32'(pulses), 32'd1);
        chk("t5_res",    32'(res_b),  32'd12);
        chk("t5_err",    32'(err_b),  32'd0);

        // Hand-driven roots: partial beat 2'b01 at cycle 3 sets err, is not summed
        man_a = 1'b1; first = -1; err4 = 1'b0;
        args_a = {32'd16, 32'd9, 32'd4}; arg_vld_a = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            arg_vld_a = 1'b0;
            man_yv_a  = 2'b00;
            man_y_a   = '0;
            if (c == 3) begin man_yv_a = 2'b01; man_y_a = {16'd0, 16'd2}; end
            if (c == 4) begin man_yv_a = 2'b11; man_y_a = {16'd3, 16'd2}; err4 = err_a; end
            if (c == 8) begin man_yv_a = 2'b11; man_y_a = {16'd0, 16'd4}; end
            if (res_vld_a && first < 0) first = c;
        end
        man_a = 1'b0;
        chk("t6_err_set",  32'(err4),  32'd1);
        chk("t6_cycle",    32'(first), 32'd10);
        chk("t6_res",      32'(res_a), 32'd9);
        chk("t6_err_hold", 32'(err_a), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
